spi_tx_feeder: RTL

- Byte source for the SPI slave transmitter. Sits in the wishbone/system clock domain, directly upstream of the SPI-clock transmit stage.
- Buffers bytes written by the peripheral logic in a small FIFO.
- Hands bytes one at a time across the clock-domain boundary using the two-phase req/ack toggle handshake that the SPI-side importer expects.
- Keeps the exported data word stable until the SPI domain acknowledges it.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_tx_feeder_sync_fifo.sv | 49 ++++
 rtl/spi_tx_feeder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI slave transmit path: byte type and the feeder's FSM states.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    WAIT_ACK
  } spi_tx_feeder_state_t;

endpackage

// File: rtl/spi_tx_feeder_sync_fifo.sv
// Single-clock circular byte buffer; extra pointer MSB distinguishes full from empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/spi_tx_feeder.sv
// Buffers bytes and offers them to the SPI clock domain over a two-phase req/ack toggle.
// Optional build macro SPI_TX_IDLE_FILL_EN: offer IDLE_BYTE once per underrun.
module spi_tx_feeder
  import spi_pkg::*;
#(
  parameter int        DEPTH     = 8,
  parameter spi_byte_t IDLE_BYTE = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_stb,
  input  logic [SPI_BYTE_W-1:0]      wr_data,
  output logic                       wr_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       handshake_req,
  input  logic                       handshake_ack,
  output logic [SPI_BYTE_W-1:0]      handshake_data
);

  localparam int LW = $clog2(DEPTH+1);

`ifdef SPI_TX_IDLE_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  spi_tx_feeder_state_t state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 req_q, req_d;
  spi_byte_t            data_q, data_d;
  logic                 fill_done_q, fill_done_d;
  logic                 ack_meta_q, ack_s_q;
  logic                 wr_ready_q, wr_ready_d;
  logic                 overflow_q;

  logic                 push, fifo_pop, fifo_full, fifo_empty;
  spi_byte_t            fifo_head;
  logic [LW-1:0]        fifo_level;

  assign push = wr_stb && wr_ready_q;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SPI_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .din_i   (wr_data),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // wr_ready is registered, so it must reflect the occupancy after this edge.
  assign wr_ready_d = !((fifo_full && !fifo_pop) ||
                        (fifo_level == LW'(DEPTH-1) && push && !fifo_pop));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    data_d      = data_q;
    fill_done_d = fill_done_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      RESYNC: begin
        // Adopt the far side's ack so a SPI domain that kept running sees no toggle.
        if (cnt_q == 2'd2) begin
          req_d   = ack_s_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          data_d      = fifo_head;
          req_d       = ~req_q;
          fill_done_d = 1'b0;
          state_d     = WAIT_ACK;
        end else if (FILL_EN && !fill_done_q) begin
          data_d      = IDLE_BYTE;
          req_d       = ~req_q;
          fill_done_d = 1'b1;
          state_d     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s_q == req_q) state_d = IDLE;
      end
      default: state_d = RESYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESYNC;
      cnt_q       <= 2'd0;
      req_q       <= 1'b0;
      data_q      <= '0;
      // Nothing has been sent yet, so there is no underrun to fill after reset.
      fill_done_q <= 1'b1;
      ack_meta_q  <= 1'b0;
      ack_s_q     <= 1'b0;
      wr_ready_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      data_q      <= data_d;
      fill_done_q <= fill_done_d;
      ack_meta_q  <= handshake_ack;
      ack_s_q     <= ack_meta_q;
      wr_ready_q  <= wr_ready_d;
      overflow_q  <= overflow_q | (wr_stb & ~wr_ready_q);
    end
  end

  assign wr_ready       = wr_ready_q;
  assign level          = fifo_level;
  assign overflow       = overflow_q;
  assign handshake_req  = req_q;
  assign handshake_data = data_q;

endmodule
